// File: rtl/sipo_pkg.sv
// Shared types and constants for the serial-in/parallel-out frame controller.
// The optional parity stage is enabled by the SIPO_PARITY_CHECK_EN macro.
package sipo_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        PAR   = 2'd2
    } state_e;

    // Bits needed to hold a count from 0 up to and including w.
    function automatic int cnt_width(input int w);
        int n;
        n = 1;
        while ((1 << n) < (w + 1)) begin
            n = n + 1;
        end
        return n;
    endfunction

endpackage

// File: rtl/sipo_shift_reg.sv
// MSB-first shift register: each enabled edge shifts left and takes SI into bit 0.
// Cleared by the synchronous active-low Reset.
module sipo_shift_reg #(
    parameter int WIDTH = 8
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             ShiftEn,
    input  logic             SI,
    output logic [WIDTH-1:0] Q
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (ShiftEn) begin
            q_d = {q_q[WIDTH-2:0], SI};
        end
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign Q = q_q;

endmodule

// File: rtl/sipo_frame_ctrl.sv
// Frame controller: start bit, WIDTH data bits (plus an even-parity bit when
// SIPO_PARITY_CHECK_EN is defined), delivered through a Valid/Ack holding register.
module sipo_frame_ctrl
    import sipo_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             SI,
    input  logic             Ack,
    output logic [WIDTH-1:0] Data,
    output logic             Valid,
    output logic             Busy,
    output logic             Overrun,
`ifdef SIPO_PARITY_CHECK_EN
    output logic             ParityErr,
`endif
    output logic [1:0]       dbg_state
);

    // Valid/Ack: Data is held while Valid=1; a word is consumed on an edge
    // where Valid=1 and Ack=1. Ack while Valid=0 has no effect.

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             overrun_q, overrun_d;

    logic             shift_en;
    logic [WIDTH-1:0] shift_q;
    logic             frame_done;
    logic [WIDTH-1:0] frame_word;

`ifdef SIPO_PARITY_CHECK_EN
    logic             perr_q, perr_d;
    logic             frame_perr;
`endif

    sipo_shift_reg #(
        .WIDTH(WIDTH)
    ) u_shift_reg (
        .Clock  (Clock),
        .Reset  (Reset),
        .ShiftEn(shift_en),
        .SI     (SI),
        .Q      (shift_q)
    );

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
`ifdef SIPO_PARITY_CHECK_EN
            perr_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            overrun_q <= overrun_d;
`ifdef SIPO_PARITY_CHECK_EN
            perr_q    <= perr_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (SI) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                end
            end
            SHIFT: begin
                if (cnt_q == LAST_BIT) begin
`ifdef SIPO_PARITY_CHECK_EN
                    state_d = PAR;
                    cnt_d   = CW'(WIDTH);
`else
                    state_d = IDLE;
                    cnt_d   = '0;
`endif
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
`ifdef SIPO_PARITY_CHECK_EN
            PAR: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
`endif
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // The last data bit is still on SI at the completing edge, so the word is
    // assembled from the register plus SI; with parity the register is already full.
    always_comb begin
        shift_en = (state_q == SHIFT);
`ifdef SIPO_PARITY_CHECK_EN
        frame_done = (state_q == PAR);
        frame_word = shift_q;
        frame_perr = (^shift_q) ^ SI;
`else
        frame_done = (state_q == SHIFT) && (cnt_q == LAST_BIT);
        frame_word = {shift_q[WIDTH-2:0], SI};
`endif
    end

    always_comb begin
        data_d    = data_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        busy_d    = (state_d != IDLE);
`ifdef SIPO_PARITY_CHECK_EN
        perr_d    = perr_q;
`endif
        if (frame_done) begin
            if (!valid_q || Ack) begin
                data_d  = frame_word;
                valid_d = 1'b1;
`ifdef SIPO_PARITY_CHECK_EN
                perr_d  = frame_perr;
`endif
                if (valid_q) begin
                    overrun_d = 1'b0;
                end
            end else begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && Ack) begin
            valid_d   = 1'b0;
            overrun_d = 1'b0;
        end
    end

    assign Data      = data_q;
    assign Valid     = valid_q;
    assign Busy      = busy_q;
    assign Overrun   = overrun_q;
    assign dbg_state = state_q;
`ifdef SIPO_PARITY_CHECK_EN
    assign ParityErr = perr_q;
`endif

endmodule

// File: tb/tb_sipo_frame_ctrl.sv
// Self-checking bench for sipo_frame_ctrl: directed frames then random traffic,
// every cycle compared against a frame-level reference model.
module tb_sipo_frame_ctrl;

    localparam int WIDTH = 8;
`ifdef SIPO_PARITY_CHECK_EN
    localparam int FLEN = WIDTH + 1;
`else
    localparam int FLEN = WIDTH;
`endif

    logic             clk;
    logic             rst_n;
    logic             si;
    logic             ack;
    logic [WIDTH-1:0] data;
    logic             valid;
    logic             busy;
    logic             overrun;
    logic [1:0]       dbg_state;
`ifdef SIPO_PARITY_CHECK_EN
    logic             perr;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    // reference model state
    bit               m_in_frame;
    bit               m_bits[$];
    logic [WIDTH-1:0] m_data;
    bit               m_valid;
    bit               m_ovr;
    bit               m_perr;

    sipo_frame_ctrl #(
        .WIDTH(WIDTH)
    ) dut (
        .Clock    (clk),
        .Reset    (rst_n),
        .SI       (si),
        .Ack      (ack),
        .Data     (data),
        .Valid    (valid),
        .Busy     (busy),
        .Overrun  (overrun),
`ifdef SIPO_PARITY_CHECK_EN
        .ParityErr(perr),
`endif
        .dbg_state(dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input bit s, input bit a, input bit r_n);
        bit               done;
        logic [WIDTH-1:0] w;
        bit               p;
        done = 0;
        w    = '0;
        p    = 0;
        if (!r_n) begin
            m_in_frame = 0;
            m_bits.delete();
            m_data  = '0;
            m_valid = 0;
            m_ovr   = 0;
            m_perr  = 0;
            return;
        end
        if (!m_in_frame) begin
            if (s) begin
                m_in_frame = 1;
                m_bits.delete();
            end
        end else begin
            m_bits.push_back(s);
            if (m_bits.size() == FLEN) begin
                m_in_frame = 0;
                done = 1;
                for (int i = 0; i < WIDTH; i++) w = {w[WIDTH-2:0], m_bits[i]};
                for (int i = 0; i < FLEN; i++) p = p ^ m_bits[i];
            end
        end
        if (done) begin
            if (!m_valid || a) begin
                if (m_valid) m_ovr = 0;
                m_data  = w;
                m_valid = 1;
                m_perr  = p;
            end else begin
                m_ovr = 1;
            end
        end else if (m_valid && a) begin
            m_valid = 0;
            m_ovr   = 0;
        end
    endtask

    task automatic check_all();
        chk("data", 32'(data), 32'(m_data));
        chk("valid", 32'(valid), 32'(m_valid));
        chk("busy", 32'(busy), 32'(m_in_frame));
        chk("overrun", 32'(overrun), 32'(m_ovr));
`ifdef SIPO_PARITY_CHECK_EN
        chk("parity_err", 32'(perr), 32'(m_perr));
`endif
    endtask

    task automatic step(input bit s, input bit a, input bit r_n);
        @(negedge clk);
        si    = s;
        ack   = a;
        rst_n = r_n;
        @(posedge clk);
        model_edge(s, a, r_n);
        #1;
        check_all();
    endtask

    task automatic send_frame(input logic [WIDTH-1:0] w, input bit par, input bit ack_last);
        step(1'b1, 1'b0, 1'b1);
        for (int i = WIDTH - 1; i >= 0; i--) begin
`ifdef SIPO_PARITY_CHECK_EN
            step(w[i], 1'b0, 1'b1);
`else
            step(w[i], (i == 0) ? ack_last : 1'b0, 1'b1);
`endif
        end
`ifdef SIPO_PARITY_CHECK_EN
        step(par, ack_last, 1'b1);
`else
        if (par) begin end
`endif
    endtask

    initial begin
        si    = 1'b0;
        ack   = 1'b0;
        rst_n = 1'b0;
        m_in_frame = 0;
        m_valid = 0;
        m_ovr = 0;
        m_perr = 0;
        m_data = '0;

        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk("reset_valid", 32'(valid), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_data", 32'(data), 32'd0);
        chk("reset_overrun", 32'(overrun), 32'd0);

        // first frame B2
        send_frame(8'hB2, 1'b0, 1'b0);
        chk("b2_data", 32'(data), 32'hB2);
        chk("b2_valid", 32'(valid), 32'd1);
        chk("b2_busy", 32'(busy), 32'd0);
`ifdef SIPO_PARITY_CHECK_EN
        chk("b2_perr0", 32'(perr), 32'd0);
`endif

        // second frame while unacknowledged is dropped
        send_frame(8'h0F, 1'b0, 1'b0);
        chk("ovr_set", 32'(overrun), 32'd1);
        chk("ovr_data_kept", 32'(data), 32'hB2);
        step(1'b0, 1'b1, 1'b1);
        chk("ack_valid_clr", 32'(valid), 32'd0);
        chk("ack_ovr_clr", 32'(overrun), 32'd0);
        step(1'b0, 1'b1, 1'b1);
        chk("ack_idle_ignored", 32'(valid), 32'd0);

        // ack on the completing edge
        send_frame(8'hB2, 1'b1, 1'b0);
`ifdef SIPO_PARITY_CHECK_EN
        chk("b2_perr1", 32'(perr), 32'd1);
`endif
        send_frame(8'h0F, 1'b0, 1'b0);
        chk("ovr_again", 32'(overrun), 32'd1);
        send_frame(8'h3C, 1'b0, 1'b1);
        chk("same_edge_data", 32'(data), 32'h3C);
        chk("same_edge_valid", 32'(valid), 32'd1);
        chk("same_edge_ovr", 32'(overrun), 32'd0);
        step(1'b0, 1'b1, 1'b1);

        // reset mid-frame
        step(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_valid", 32'(valid), 32'd0);
        send_frame(8'hA5, 1'b0, 1'b0);
        chk("a5_data", 32'(data), 32'hA5);
        step(1'b0, 1'b1, 1'b1);

        // long idle
        for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b1);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_valid", 32'(valid), 32'd0);

        // random traffic, including back-to-back frames and occasional resets
        for (int i = 0; i < 2000; i++) begin
            step(1'($urandom_range(0, 2) != 0),
                 1'($urandom_range(0, 3) == 0),
                 1'($urandom_range(0, 199) != 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
